lfsr_prng_multi: RTL and testbench
==================================

// Module: lfsr_prng_multi
// PURPOSE
//  Multi-channel Galois LFSR pseudo-random word generator for NoC traffic/payload stimulus.
//  NUM_CH independent LFSRs, each with a valid/ready output port, runtime seed load,
//  all-zero lock-up guard and period-wrap flag. Sits between the traffic source
//  controller (drives I_EN/seed) and per-router packet injectors (consume O_DATA).
// PARAMETERS
//  WIDTH         16        LFSR state and output word width (>=3)
//  NUM_CH        4         number of independent channels (1..WIDTH)
//  TAPS          16'hB400  Galois feedback mask, WIDTH bits; must give maximal-length polynomial
//  DEFAULT_SEED  16'h0001  reset/substitute seed, WIDTH bits, nonzero
// PORTS
//  CLK        in   1             clock, rising edge
//  RST_N      in   1             asynchronous, active-low reset
//  I_EN       in   1             generation enable (global)
//  I_SEED_LD  in   1             one-cycle pulse: load I_SEED into all channels
//  I_SEED     in   WIDTH         seed value for I_SEED_LD
//  I_READY    in   NUM_CH        per-channel consumer ready
//  O_VALID    out  NUM_CH        per-channel data valid
//  O_DATA     out  NUM_CH*WIDTH  channel c at [c*WIDTH +: WIDTH]
//  O_WRAP     out  NUM_CH        per-channel 1-cycle pulse: sequence returned to its seed
// BEHAVIOUR
//  - Channel seed: seed_c = rotl(S, c) over WIDTH bits; S = DEFAULT_SEED at reset, else
//    I_SEED at load, replaced by DEFAULT_SEED when I_SEED==0 (lock-up guard).
//  - Step: next(s) = (s >> 1) ^ (s[0] ? TAPS : '0). Never reaches 0 from nonzero seed.
//  - Reset: state_c=seed_c(DEFAULT_SEED), stored seed_c likewise, O_VALID=0, O_DATA=0, O_WRAP=0.
//  - Output register per channel (1-deep, no skid). Per cycle, priority order:
//    1. I_SEED_LD=1: state_c<=seed_c, stored seed_c<=seed_c, O_VALID<=0, O_WRAP<=0 (flush,
//       all channels, even if valid&!ready; in-flight word is dropped).
//    2. O_VALID[c]&!I_READY[c]: hold O_DATA/O_VALID stable, state frozen (independent of I_EN).
//    3. I_EN=1 (slot free: !O_VALID[c] | I_READY[c]): O_DATA_c<=state_c, O_VALID[c]<=1,
//       state_c<=next(state_c).
//    4. I_EN=0, slot free: O_VALID[c]<=0, O_DATA holds last value, state frozen.
//  - Latency: I_EN rise at cycle N -> O_VALID=1 at N+1 with word = state_c. With READY held
//    high, one new word per cycle per channel; channels advance independently under backpressure.
//  - O_WRAP[c]=1 for exactly the cycle after a step whose next(state_c)==stored seed_c, i.e.
//    concurrent with the last word of the period being valid (255th word for WIDTH=8).
//  - I_SEED_LD while I_EN=1: load wins that cycle; first new word valid at following cycle+1.
//  - RST_N assert mid-stream: all outputs to reset values asynchronously; no partial state.
// STRUCTURE
//  - Package lfsr_pkg: default TAPS constants (LFSR_TAPS_8=8'hB8, LFSR_TAPS_16=16'hB400,
//    LFSR_TAPS_32=32'h80200003), function rotl(value, amount), function galois_next(s, taps).
//  - Sub-module lfsr_galois_ch: one channel (state, stored seed, output reg, valid, wrap);
//    top instantiates NUM_CH via generate, computes seed_c and fans out I_EN/I_SEED_LD.
//  - Elaboration checks: DEFAULT_SEED!=0, NUM_CH<=WIDTH.
// TESTING (WIDTH=8, NUM_CH=2, TAPS=8'hB8, DEFAULT_SEED=8'h01 unless noted)
//  1. Reset release, I_EN=1, READY=2'b11 -> ch0 words 01,B8,5C,2E...; ch1 words 02,01,B8...;
//     O_VALID first high 1 cycle after I_EN.
//  2. Free-run ch0 READY=1 -> O_WRAP[0] pulses once after 255 accepted words, word 256 = 01
//     again; compare full sequence to reference model using galois_next.
//  3. Backpressure: READY[0]=0 for 5 cycles while valid -> O_DATA ch0 stable, ch1 still
//     advances; on READY[0]=1 ch0 resumes with next value, no skip/duplicate.
//  4. I_SEED_LD with I_SEED=8'h5A mid-stream, one channel stalled -> O_VALID=0 next cycle,
//     then ch0 emits 5A, ch1 emits B4; I_SEED=8'h00 -> substitutes 01/02.
//  5. I_EN toggled 1-0-1 with READY=1 -> O_VALID drops 1 cycle after I_EN falls, sequence
//     continues without gaps on re-enable.
//  6. Async RST_N pulse mid-stream (between clock edges) -> O_VALID/O_WRAP/O_DATA=0
//     immediately; after release sequence restarts at 01/02.

Source files
------------

// File: rtl/lfsr_prng_multi_pkg.sv
// lfsr_pkg: shared LFSR tap constants and width-agnostic helper functions
package lfsr_pkg;

    localparam int LFSR_MAX_W = 64;

    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

    // Rotate left over the low `width` bits; bits above `width` are ignored.
    function automatic logic [LFSR_MAX_W-1:0] rotl(
        input logic [LFSR_MAX_W-1:0] value,
        input int                    amount,
        input int                    width
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] v;
        int                    a;
        a    = amount % width;
        mask = (width >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1));
        v    = value & mask;
        return ((v << a) | (v >> (width - a))) & mask;
    endfunction

    // One Galois step; valid for any width as long as the upper bits of s and taps are zero.
    function automatic logic [LFSR_MAX_W-1:0] galois_next(
        input logic [LFSR_MAX_W-1:0] s,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/lfsr_galois_ch.sv
// lfsr_galois_ch: one Galois LFSR channel with 1-deep valid/ready output register and wrap flag
module lfsr_galois_ch
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter logic [WIDTH-1:0] RST_SEED = 16'h0001
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    input  logic             seed_ld,
    input  logic [WIDTH-1:0] seed,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             wrap
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] nxt;

    assign nxt = WIDTH'(galois_next(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS)));

    // Seed load flushes; a stalled word freezes everything; otherwise emit and step when enabled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= RST_SEED;
            seed_q <= RST_SEED;
            valid  <= 1'b0;
            data   <= '0;
            wrap   <= 1'b0;
        end else if (seed_ld) begin
            state  <= seed;
            seed_q <= seed;
            valid  <= 1'b0;
            wrap   <= 1'b0;
        end else if (valid && !ready) begin
            wrap   <= 1'b0;
        end else if (en) begin
            data   <= state;
            valid  <= 1'b1;
            state  <= nxt;
            wrap   <= (nxt == seed_q);
        end else begin
            valid  <= 1'b0;
            wrap   <= 1'b0;
        end
    end

endmodule

// File: rtl/lfsr_prng_multi.sv
// lfsr_prng_multi: NUM_CH independent Galois LFSR word generators with shared enable and seed load
module lfsr_prng_multi
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               NUM_CH       = 4,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h0001
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    I_EN,
    input  logic                    I_SEED_LD,
    input  logic [WIDTH-1:0]        I_SEED,
    input  logic [NUM_CH-1:0]       I_READY,
    output logic [NUM_CH-1:0]       O_VALID,
    output logic [NUM_CH*WIDTH-1:0] O_DATA,
    output logic [NUM_CH-1:0]       O_WRAP
);

    if (DEFAULT_SEED == '0) begin : g_bad_seed
        $error("lfsr_prng_multi: DEFAULT_SEED must be nonzero");
    end
    if (NUM_CH < 1 || NUM_CH > WIDTH || WIDTH < 3) begin : g_bad_ch
        $error("lfsr_prng_multi: need WIDTH>=3 and 1<=NUM_CH<=WIDTH");
    end

    // An all-zero seed would lock the LFSR, so it is replaced by the default.
    logic [WIDTH-1:0] base_seed;
    assign base_seed = (I_SEED == '0) ? DEFAULT_SEED : I_SEED;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [WIDTH-1:0] RST_SEED_C = WIDTH'(rotl(LFSR_MAX_W'(DEFAULT_SEED), c, WIDTH));
        logic [WIDTH-1:0] seed_c;
        assign seed_c = WIDTH'(rotl(LFSR_MAX_W'(base_seed), c, WIDTH));
        lfsr_galois_ch #(
            .WIDTH    (WIDTH),
            .TAPS     (TAPS),
            .RST_SEED (RST_SEED_C)
        ) u_ch (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .en      (I_EN),
            .seed_ld (I_SEED_LD),
            .seed    (seed_c),
            .ready   (I_READY[c]),
            .valid   (O_VALID[c]),
            .data    (O_DATA[c*WIDTH +: WIDTH]),
            .wrap    (O_WRAP[c])
        );
    end

endmodule

// File: tb/tb_lfsr_prng_multi.sv
// tb_lfsr_prng_multi: directed vector bench for a 2-channel 8-bit LFSR generator
module tb_lfsr_prng_multi;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        I_EN;
    logic        I_SEED_LD;
    logic [7:0]  I_SEED;
    logic [1:0]  I_READY;
    logic [1:0]  O_VALID;
    logic [15:0] O_DATA;
    logic [1:0]  O_WRAP;

    int vec  = 0;
    int miss = 0;

    lfsr_prng_multi #(
        .WIDTH        (8),
        .NUM_CH       (2),
        .TAPS         (8'hB8),
        .DEFAULT_SEED (8'h01)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .I_EN      (I_EN),
        .I_SEED_LD (I_SEED_LD),
        .I_SEED    (I_SEED),
        .I_READY   (I_READY),
        .O_VALID   (O_VALID),
        .O_DATA    (O_DATA),
        .O_WRAP    (O_WRAP)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] ref_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
        chk({tag, " valid"}, 32'(O_VALID), 32'(v));
        chk({tag, " d0"}, 32'(O_DATA[7:0]), 32'(d0));
        chk({tag, " d1"}, 32'(O_DATA[15:8]), 32'(d1));
    endtask

    logic [7:0] m0, m1;

    initial begin
        RST_N = 1'b0; I_EN = 1'b0; I_SEED_LD = 1'b0; I_SEED = 8'h00; I_READY = 2'b11;
        #2;
        chk_out("reset", 2'b00, 8'h00, 8'h00);
        chk("reset wrap", 32'(O_WRAP), 32'h0);
        @(negedge CLK); @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("idle valid", 32'(O_VALID), 32'h0);

        I_EN = 1'b1;
        @(negedge CLK); chk_out("t1 w1", 2'b11, 8'h01, 8'h02);
        @(negedge CLK); chk_out("t1 w2", 2'b11, 8'hB8, 8'h01);
        @(negedge CLK); chk_out("t1 w3", 2'b11, 8'h5C, 8'hB8);
        @(negedge CLK); chk_out("t1 w4", 2'b11, 8'h2E, 8'h5C);

        m0 = 8'h17; m1 = 8'h2E;
        for (int k = 5; k <= 256; k++) begin
            @(negedge CLK);
            chk_out("t2 run", 2'b11, m0, m1);
            chk("t2 wrap", 32'(O_WRAP), (k == 255) ? 32'h3 : 32'h0);
            m0 = ref_next(m0); m1 = ref_next(m1);
        end
        chk("t2 word256", 32'(O_DATA[7:0]), 32'h01);

        I_READY = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk_out("t3 stall", 2'b11, 8'h01, m1);
            m1 = ref_next(m1);
        end
        I_READY = 2'b11;
        @(negedge CLK);
        chk_out("t3 resume", 2'b11, 8'hB8, m1);

        I_READY = 2'b10;
        @(negedge CLK);
        I_SEED = 8'h5A; I_SEED_LD = 1'b1;
        @(negedge CLK);
        I_SEED_LD = 1'b0; I_READY = 2'b11;
        chk("t4 flush valid", 32'(O_VALID), 32'h0);
        chk("t4 flush wrap", 32'(O_WRAP), 32'h0);
        @(negedge CLK); chk_out("t4 5A", 2'b11, 8'h5A, 8'hB4);
        @(negedge CLK); chk_out("t4 5A+1", 2'b11, 8'h2D, 8'h5A);
        @(negedge CLK); chk_out("t4 5A+2", 2'b11, 8'hAE, 8'h2D);
        I_SEED = 8'h00; I_SEED_LD = 1'b1;
        @(negedge CLK);
        I_SEED_LD = 1'b0;
        chk("t4 zero flush", 32'(O_VALID), 32'h0);
        @(negedge CLK); chk_out("t4 zero sub", 2'b11, 8'h01, 8'h02);

        I_EN = 1'b0;
        @(negedge CLK); chk_out("t5 off1", 2'b00, 8'h01, 8'h02);
        @(negedge CLK); chk_out("t5 off2", 2'b00, 8'h01, 8'h02);
        I_EN = 1'b1;
        @(negedge CLK); chk_out("t5 on1", 2'b11, 8'hB8, 8'h01);
        @(negedge CLK); chk_out("t5 on2", 2'b11, 8'h5C, 8'hB8);

        #2 RST_N = 1'b0;
        #1;
        chk_out("t6 async", 2'b00, 8'h00, 8'h00);
        chk("t6 wrap", 32'(O_WRAP), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK); chk_out("t6 restart1", 2'b11, 8'h01, 8'h02);
        @(negedge CLK); chk_out("t6 restart2", 2'b11, 8'hB8, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
